cia_tod_counter: RTL and testbench

CIA_TOD_COUNTER -- requirements
Module: cia_tod_counter

---
 rtl/cia_pkg.sv | 15 +
 rtl/cia_tod_inc.sv | 27 ++
 rtl/cia_tod_counter.sv | 98 +++++++++
 tb/tb_cia_tod_counter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cia_pkg.sv
// Shared constants for the CIA time-of-day block: CRB bit positions, default width
// and the nibble increment used by the counter's carry chain.
package cia_pkg;

  localparam int NBYTES_DEF = 3;
  localparam int CRB_ALARM  = 7;
  localparam int CRB_BCD    = 6;

  // Returns {carry, nibble+1}; in BCD mode a nibble at 9 (or above) rolls to 0 with carry.
  function automatic logic [4:0] nib_inc(input logic [3:0] n, input logic bcd);
    if (bcd) return (n >= 4'd9) ? 5'b1_0000 : {1'b0, n + 4'd1};
    return {1'b0, n} + 5'd1;
  endfunction

endpackage

// File: rtl/cia_tod_inc.sv
// Ripple increment of the whole tod value, one digit at a time, binary or BCD.
module cia_tod_inc
  import cia_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic                  bcd,
  input  logic [8*NBYTES-1:0]   d,
  output logic [8*NBYTES-1:0]   q
);

  always_comb begin
    logic       c;
    logic [4:0] r;
    q = d;
    c = 1'b1;
    r = '0;
    for (int i = 0; i < 2*NBYTES; i++) begin
      if (c) begin
        r = nib_inc(d[4*i +: 4], bcd);
        q[4*i +: 4] = r[3:0];
        c = r[4];
      end
    end
  end

endmodule

// File: rtl/cia_tod_counter.sv
// CIA-style time-of-day counter with read latch, alarm compare and one-clock irq.
// Optional BCD counting (CRB bit 6) is built only when CIA_TOD_BCD_EN is defined.
module cia_tod_counter
  import cia_pkg::*;
#(
  parameter int                  NBYTES    = NBYTES_DEF,
  parameter logic [8*NBYTES-1:0] ALARM_RST = '1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk7_en,
  input  logic              wr,
  input  logic [NBYTES-1:0] tsel,
  input  logic              tcr,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  input  logic              count,
  output logic              irq
);

  localparam int W   = 8*NBYTES;
  localparam int MSB = NBYTES-1;

  logic [W-1:0] tod, tod_inc, tod_latch, alarm;
  logic         crb7, mode, count_ena, latch_ena, count_prev;
  logic         edge_det, tod_wr, tod_rd, inc_fire;
  logic [7:0]   crb_val;

  assign edge_det = count & ~count_prev;
  assign tod_wr   = wr & ~crb7 & (|tsel);
  assign tod_rd   = ~wr & ~crb7;
  // A tod write in the same enabled cycle swallows the count edge.
  assign inc_fire = clk7_en & edge_det & count_ena & ~tod_wr;

  cia_tod_inc #(.NBYTES(NBYTES)) u_inc (
    .bcd (mode),
    .d   (tod),
    .q   (tod_inc)
  );

`ifdef CIA_TOD_BCD_EN
  logic mode_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mode_q <= 1'b0;
    else if (clk7_en && wr && tcr) mode_q <= data_in[CRB_BCD];
  end
  assign mode = mode_q;
`else
  assign mode = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tod        <= '0;
      alarm      <= ALARM_RST;
      tod_latch  <= '0;
      crb7       <= 1'b0;
      count_ena  <= 1'b1;
      latch_ena  <= 1'b1;
      count_prev <= 1'b0;
      irq        <= 1'b0;
    end else begin
      // Cleared on every clk so the pulse is one clk wide regardless of clk7_en.
      irq <= inc_fire && (tod_inc == alarm);
      if (clk7_en) begin
        count_prev <= count;
        if (latch_ena) tod_latch <= tod;
        if (wr && tcr) crb7 <= data_in[CRB_ALARM];
        for (int i = 0; i < NBYTES; i++) begin
          if (wr && tsel[i]) begin
            if (crb7) alarm[8*i +: 8] <= data_in;
            else      tod[8*i +: 8]   <= data_in;
          end
        end
        if (inc_fire) tod <= tod_inc;
        // With NBYTES=1 MSB and LSB coincide and the set wins.
        if (tod_wr && tsel[MSB]) count_ena <= 1'b0;
        if (tod_wr && tsel[0])   count_ena <= 1'b1;
        if (tod_rd && tsel[MSB]) latch_ena <= 1'b0;
        if (tod_rd && tsel[0])   latch_ena <= 1'b1;
      end
    end
  end

  always_comb begin
    crb_val            = '0;
    crb_val[CRB_ALARM] = crb7;
    crb_val[CRB_BCD]   = mode;
    data_out           = 8'h00;
    if (!wr) begin
      if (tcr) data_out = crb_val;
      for (int i = 0; i < NBYTES; i++) begin
        if (tsel[i]) data_out = tod_latch[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_cia_tod_counter.sv
// Scoreboarded bench for cia_tod_counter: directed scenarios plus randomized bus/count traffic.
module tb_cia_tod_counter;
  import cia_pkg::*;

  localparam int NB = NBYTES_DEF;
  localparam int W  = 8*NB;

  logic          clk = 1'b0, reset_n = 1'b0, clk7_en = 1'b0, wr = 1'b0, tcr = 1'b0, count = 1'b0;
  logic [NB-1:0] tsel = '0;
  logic [7:0]    data_in = 8'h00;
  logic [7:0]    data_out;
  logic          irq;

  always #5 clk = ~clk;

  cia_tod_counter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk7_en  (clk7_en),
    .wr       (wr),
    .tsel     (tsel),
    .tcr      (tcr),
    .data_in  (data_in),
    .data_out (data_out),
    .count    (count),
    .irq      (irq)
  );

  typedef struct { logic [7:0] dout; logic irq; } exp_t;
  exp_t sb_q[$];
  exp_t me;
  int   errors = 0, checks = 0, irq_cnt = 0;
  bit   mon_en = 1'b0;

  // Reference state: plain integers following the register-level behaviour.
  longint unsigned m_tod, m_alarm, m_latch;
  bit m_crb7, m_mode, m_cena, m_lena, m_prev, m_irq;
  bit cnt_lvl = 1'b0, en_lvl = 1'b1;

  function automatic longint unsigned byte_of(longint unsigned v, int k);
    return (v >> (8*k)) & 64'hFF;
  endfunction

  function automatic longint unsigned set_byte(longint unsigned v, int k, logic [7:0] d);
    return (v & ~(64'hFF << (8*k))) | (64'(d) << (8*k));
  endfunction

  function automatic longint unsigned next_tod(longint unsigned v, bit bcd);
    longint unsigned dec, p;
    if (!bcd) return (v + 1) % (64'd1 << W);
    dec = 0; p = 1;
    for (int i = 0; i < 2*NB; i++) begin
      dec += ((v >> (4*i)) & 15) * p;
      p   *= 10;
    end
    dec = (dec + 1) % p;
    v = 0;
    for (int i = 0; i < 2*NB; i++) begin
      v |= (dec % 10) << (4*i);
      dec /= 10;
    end
    return v;
  endfunction

  task automatic m_reset();
    m_tod = 0; m_alarm = (64'd1 << W) - 1; m_latch = 0;
    m_crb7 = 0; m_mode = 0; m_cena = 1; m_lena = 1; m_prev = 0; m_irq = 0;
  endtask

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // One bus cycle: push the expected outputs for this cycle, then advance the model.
  task automatic cyc(bit w, logic [NB-1:0] ts, bit t, logic [7:0] d, int exp_dout = -1);
    exp_t e;
    logic [7:0] dm;
    bit edge_c, twr, fire;
    longint unsigned nt, na;
    clk7_en = en_lvl; wr = w; tsel = ts; tcr = t; data_in = d; count = cnt_lvl;
    dm = 8'h00;
    if (!w) begin
      if (t) dm = {m_crb7, m_mode, 6'b0};
      for (int k = NB-1; k >= 0; k--) begin
        if (ts[k]) begin
          dm = 8'(byte_of(m_latch, k));
          break;
        end
      end
    end
    e.dout = (exp_dout >= 0) ? exp_dout[7:0] : dm;
    e.irq  = m_irq;
    sb_q.push_back(e);
    m_irq = 0;
    if (en_lvl) begin
      edge_c = cnt_lvl && !m_prev;
      twr    = w && !m_crb7 && (ts != '0);
      fire   = edge_c && m_cena && !twr;
      nt = m_tod; na = m_alarm;
      if (w) begin
        for (int k = 0; k < NB; k++) begin
          if (ts[k]) begin
            if (m_crb7) na = set_byte(na, k, d);
            else        nt = set_byte(nt, k, d);
          end
        end
      end
      if (fire) begin
        nt    = next_tod(m_tod, m_mode);
        m_irq = (nt == m_alarm);
      end
      if (m_lena) m_latch = m_tod;
      if (twr && ts[NB-1]) m_cena = 0;
      if (twr && ts[0])    m_cena = 1;
      if (!w && !m_crb7 && ts[NB-1]) m_lena = 0;
      if (!w && !m_crb7 && ts[0])    m_lena = 1;
      if (w && t) begin
        m_crb7 = d[7];
`ifdef CIA_TOD_BCD_EN
        m_mode = d[6];
`endif
      end
      m_prev = cnt_lvl; m_tod = nt; m_alarm = na;
    end
    @(posedge clk); #1;
  endtask

  task automatic onehot(int k, output logic [NB-1:0] ts);
    ts = '0; ts[k] = 1'b1;
  endtask
  task automatic rd_byte(int k, int exp = -1);
    logic [NB-1:0] ts; onehot(k, ts); cyc(1'b0, ts, 1'b0, 8'h00, exp);
  endtask
  task automatic wr_byte(int k, logic [7:0] d);
    logic [NB-1:0] ts; onehot(k, ts); cyc(1'b1, ts, 1'b0, d);
  endtask
  task automatic rd_tcr(int exp = -1); cyc(1'b0, '0, 1'b1, 8'h00, exp); endtask
  task automatic wr_tcr(logic [7:0] d); cyc(1'b1, '0, 1'b1, d); endtask
  task automatic idle(int n); repeat (n) cyc(1'b0, '0, 1'b0, 8'h00); endtask
  task automatic pulse();
    cnt_lvl = 1'b1; idle(4); cnt_lvl = 1'b0; idle(2);
  endtask
  task automatic chk_tod(longint unsigned v);
    for (int k = NB-1; k >= 0; k--) rd_byte(k, int'(byte_of(v, k)));
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    wr = 1'b0; tcr = 1'b0; tsel = '0; tsel[0] = 1'b1; count = 1'b0; cnt_lvl = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_irq", int'(irq), 0);
    chk("rst_latch_lsb", int'(data_out), 0);
    @(posedge clk); #1;
    reset_n = 1'b1; tsel = '0;
    m_reset();
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (irq === 1'b1) irq_cnt++;
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty no expectation queued");
      end else begin
        me = sb_q.pop_front();
        checks++;
        if (data_out !== me.dout) begin
          errors++;
          $display("FAIL data_out got=%02h want=%02h t=%0t", data_out, me.dout, $time);
        end
        checks++;
        if (irq !== me.irq) begin
          errors++;
          $display("FAIL irq got=%0b want=%0b t=%0t", irq, me.irq, $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int irq0;
    logic [NB-1:0] ts;
    m_reset();
    repeat (3) @(posedge clk);
    #1; reset_n = 1'b1; mon_en = 1'b1;

    chk_tod(0); rd_tcr(0); idle(2);

    repeat (5) pulse();
    chk_tod(64'h000005);

    wr_byte(2, 8'h12); wr_byte(1, 8'hFF); wr_byte(0, 8'hFF); idle(2);
    rd_byte(2, 8'h12); pulse(); rd_byte(1, 8'hFF); rd_byte(0, 8'hFF);
    idle(1); rd_byte(0, 8'h00); chk_tod(64'h130000);

    wr_tcr(8'h80); rd_tcr(8'h80);
    wr_byte(2, 8'h00); wr_byte(1, 8'h00); wr_byte(0, 8'h10);
    wr_tcr(8'h00); rd_tcr(8'h00);
    wr_byte(2, 8'h00); wr_byte(1, 8'h00); wr_byte(0, 8'h0F); idle(1);
    irq0 = irq_cnt;
    pulse();
    chk("irq_pulse_len", irq_cnt - irq0, 1);
    chk_tod(64'h000010);
    irq0 = irq_cnt;
    wr_byte(0, 8'h10); idle(2);
    chk("irq_on_write", irq_cnt - irq0, 0);

    wr_byte(1, 8'h00); wr_byte(2, 8'h01);
    repeat (3) pulse();
    wr_byte(0, 8'h00); idle(1);
    chk_tod(64'h010000);
    pulse();
    chk_tod(64'h010001);

    cnt_lvl = 1'b1; wr_byte(0, 8'h55); idle(2); cnt_lvl = 1'b0; idle(2);
    chk_tod(64'h010055);

    ts = '0; ts[1] = 1'b1; ts[0] = 1'b1;
    cyc(1'b0, ts, 1'b1, 8'h00, 8'h00);
    onehot(0, ts);
    cyc(1'b0, ts, 1'b1, 8'h00, 8'h55);

`ifdef CIA_TOD_BCD_EN
    wr_tcr(8'h40); rd_tcr(8'h40);
    wr_byte(2, 8'h09); wr_byte(1, 8'h99); wr_byte(0, 8'h99); idle(1);
    pulse();
    chk_tod(64'h100000);
    wr_tcr(8'h00);
`else
    wr_tcr(8'h40); rd_tcr(8'h00); wr_tcr(8'h00);
`endif

    wr_byte(2, 8'h07); rd_byte(2);
    do_reset();
    pulse();
    chk_tod(64'h000001); rd_tcr(0);

    wr_byte(2, 8'hFF); wr_byte(1, 8'hFF); wr_byte(0, 8'hFD);
    for (int n = 0; n < 300; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      en_lvl = ($urandom_range(0, 3) != 0);
      case (op)
        0, 1, 2: begin cnt_lvl = 1'($urandom_range(0, 1)); idle(1); end
        3, 4:    rd_byte(int'($urandom_range(0, NB-1)));
        5:       wr_byte(int'($urandom_range(0, NB-1)), 8'($urandom));
        6:       rd_tcr();
`ifdef CIA_TOD_BCD_EN
        7:       wr_tcr(8'($urandom) & 8'h3F);
`else
        7:       wr_tcr(8'($urandom) & 8'h7F);
`endif
        default: idle(1);
      endcase
    end
    en_lvl = 1'b1; cnt_lvl = 1'b0;
    idle(2);
    mon_en = 1'b0;
    chk("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
